// File: rtl/ddr3_test_traffic_gen.sv
// DDR3 soak-test stimulus: writes a linear pattern region, then reads it back in order.
// Optional read-in-flight limit enabled by defining DDR3_TEST_GEN_OUTSTANDING_LIMIT_EN.
module ddr3_test_traffic_gen #(
    parameter int COUNT_BITS      = 25,
    parameter int ADDR_WIDTH      = 25,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ddr3_init_done,
    input  logic                  ddr3_cal_success,
    input  logic                  ddr3_cal_fail,
    input  logic                  avl_ready,
    input  logic                  avl_rdata_valid,
    output logic                  avl_write_req,
    output logic                  avl_read_req,
    output logic                  avl_burstbegin,
    output logic [ADDR_WIDTH-1:0] avl_addr,
    output logic [63:0]           avl_wdata,
    output logic [7:0]            avl_be,
    output logic [2:0]            avl_size,
    output logic                  writes_done,
    output logic                  reads_done,
    output logic                  gen_fail
);

    localparam logic [COUNT_BITS-1:0] LAST = COUNT_BITS'(1) << (COUNT_BITS - 1);
    localparam logic [63:0] PATTERN = 64'hdeadfadebabebeef;

    typedef enum logic [2:0] {
        S_WAIT_FOR_INIT,
        S_WRITE,
        S_READ,
        S_FINISHED,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNT_BITS-1:0]   idx_q, idx_d;
    logic                    write_req_q, write_req_d;
    logic                    read_req_q, read_req_d;
    logic                    burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [63:0]             wdata_q, wdata_d;
    logic                    writes_done_q, writes_done_d;
    logic                    reads_done_q, reads_done_d;
    logic                    gen_fail_q, gen_fail_d;
    logic                    wr_acc, rd_acc, rd_ok;

    assign wr_acc = write_req_q && avl_ready;
    assign rd_acc = read_req_q && avl_ready;

`ifdef DDR3_TEST_GEN_OUTSTANDING_LIMIT_EN
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] outst_q, outst_d;

    // Limit is judged on the post-update count so the registered request
    // drops in the cycle right after the accept that fills the window.
    always_comb begin
        outst_d = outst_q;
        if (rd_acc && !avl_rdata_valid)
            outst_d = outst_q + 1'b1;
        else if (!rd_acc && avl_rdata_valid && outst_q != '0)
            outst_d = outst_q - 1'b1;
        rd_ok = outst_d < MAX_CNT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) outst_q <= '0;
        else          outst_q <= outst_d;
    end
`else
    logic unused_rdata_valid;
    assign unused_rdata_valid = avl_rdata_valid;
    assign rd_ok = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        write_req_d   = 1'b0;
        read_req_d    = 1'b0;
        writes_done_d = writes_done_q;
        reads_done_d  = reads_done_q;
        gen_fail_d    = gen_fail_q;
        case (state_q)
            S_WAIT_FOR_INIT: begin
                if (ddr3_init_done && ddr3_cal_success) begin
                    state_d     = S_WRITE;
                    write_req_d = 1'b1;
                end else if (ddr3_init_done && ddr3_cal_fail) begin
                    state_d    = S_ERROR;
                    gen_fail_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_acc && idx_q == LAST) begin
                    idx_d         = '0;
                    writes_done_d = 1'b1;
                    state_d       = S_READ;
                    read_req_d    = rd_ok;
                end else begin
                    if (wr_acc) idx_d = idx_q + 1'b1;
                    write_req_d = 1'b1;
                end
            end
            S_READ: begin
                if (rd_acc && idx_q == LAST) begin
                    reads_done_d = 1'b1;
                    state_d      = S_FINISHED;
                end else begin
                    if (rd_acc) idx_d = idx_q + 1'b1;
                    read_req_d = rd_ok;
                end
            end
            S_FINISHED: ;
            S_ERROR: gen_fail_d = 1'b1;
            default: begin
                state_d    = S_ERROR;
                gen_fail_d = 1'b1;
            end
        endcase
        burst_d = write_req_d | read_req_d;
        addr_d  = ADDR_WIDTH'(idx_d);
        wdata_d = PATTERN ^ 64'(idx_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_WAIT_FOR_INIT;
            idx_q         <= '0;
            write_req_q   <= 1'b0;
            read_req_q    <= 1'b0;
            burst_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            writes_done_q <= 1'b0;
            reads_done_q  <= 1'b0;
            gen_fail_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            write_req_q   <= write_req_d;
            read_req_q    <= read_req_d;
            burst_q       <= burst_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            writes_done_q <= writes_done_d;
            reads_done_q  <= reads_done_d;
            gen_fail_q    <= gen_fail_d;
        end
    end

    assign avl_write_req  = write_req_q;
    assign avl_read_req   = read_req_q;
    assign avl_burstbegin = burst_q;
    assign avl_addr       = addr_q;
    assign avl_wdata      = wdata_q;
    assign avl_be         = 8'hff;
    assign avl_size       = 3'd1;
    assign writes_done    = writes_done_q;
    assign reads_done     = reads_done_q;
    assign gen_fail       = gen_fail_q;

endmodule

// File: tb/tb_ddr3_test_traffic_gen.sv
// Directed bench for ddr3_test_traffic_gen with COUNT_BITS=4 (9 words).
// Limit checks are compiled in when DDR3_TEST_GEN_OUTSTANDING_LIMIT_EN is defined.
module tb_ddr3_test_traffic_gen;

    localparam int CB = 4;
    localparam int AW = 8;
    localparam int MO = 2;
    localparam logic [63:0] PAT = 64'hdeadfadebabebeef;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic init_done = 1'b0;
    logic cal_success = 1'b0;
    logic cal_fail = 1'b0;
    logic avl_ready = 1'b0;
    logic avl_rdata_valid = 1'b0;
    logic avl_write_req, avl_read_req, avl_burstbegin;
    logic [AW-1:0] avl_addr;
    logic [63:0] avl_wdata;
    logic [7:0] avl_be;
    logic [2:0] avl_size;
    logic writes_done, reads_done, gen_fail;

    int n_assert = 0;
    int n_fail = 0;
    int n_rd = 0;
    int nreq, bp;
    bit both, found, seen_rd;
    bit q_wr[$];
    logic [AW-1:0] q_addr[$];
    logic [63:0] q_wdata[$];

    ddr3_test_traffic_gen #(
        .COUNT_BITS(CB),
        .ADDR_WIDTH(AW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ddr3_init_done(init_done),
        .ddr3_cal_success(cal_success),
        .ddr3_cal_fail(cal_fail),
        .avl_ready(avl_ready),
        .avl_rdata_valid(avl_rdata_valid),
        .avl_write_req(avl_write_req),
        .avl_read_req(avl_read_req),
        .avl_burstbegin(avl_burstbegin),
        .avl_addr(avl_addr),
        .avl_wdata(avl_wdata),
        .avl_be(avl_be),
        .avl_size(avl_size),
        .writes_done(writes_done),
        .reads_done(reads_done),
        .gen_fail(gen_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Log the command that the next rising edge will accept, then advance.
    task automatic step();
        if ((avl_write_req || avl_read_req) && avl_ready) begin
            q_wr.push_back(avl_write_req);
            q_addr.push_back(avl_addr);
            q_wdata.push_back(avl_wdata);
            if (avl_read_req) n_rd++;
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr", avl_write_req, 0);
        check("rst_rd", avl_read_req, 0);
        check("rst_bb", avl_burstbegin, 0);
        check("rst_flags", {writes_done, reads_done, gen_fail}, 0);
        check("rst_be", avl_be, 8'hff);
        check("rst_size", avl_size, 3'd1);
        check("rst_addr", avl_addr, 0);
        check("rst_wdata", avl_wdata, 0);

        // Calibration failure
        reset_n = 1'b1;
        init_done = 1'b1;
        cal_fail = 1'b1;
        avl_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("calfail_gen_fail", gen_fail, 1);
        nreq = 0;
        repeat (100) begin
            if (avl_write_req || avl_read_req) nreq++;
            @(negedge clk);
        end
        check("calfail_no_req", nreq, 0);
        check("calfail_sticky", gen_fail, 1);

        // Full run with a 5-cycle stall on write address 3
        reset_n = 1'b0;
        cal_fail = 1'b0;
        repeat (2) @(negedge clk);
        check("rerst_gen_fail", gen_fail, 0);
        q_wr.delete(); q_addr.delete(); q_wdata.delete();
        reset_n = 1'b1;
        cal_success = 1'b1;
        bp = 0; both = 1'b0; seen_rd = 1'b0;
        for (int c = 0; c < 100 && !reads_done; c++) begin
            if (avl_write_req && avl_read_req) both = 1'b1;
            if (avl_read_req && !seen_rd) begin
                seen_rd = 1'b1;
                check("wd_at_first_read", writes_done, 1);
                check("rd_not_done_yet", reads_done, 0);
            end
            if (avl_write_req && avl_addr == 3 && bp < 5) begin
                avl_ready = 1'b0;
                check("bp_addr", avl_addr, 3);
                check("bp_wdata", avl_wdata, PAT ^ 64'd3);
                check("bp_bb", avl_burstbegin, 1);
                bp++;
            end else begin
                avl_ready = 1'b1;
            end
            step();
        end
        avl_ready = 1'b1;
        check("bp_cycles", bp, 5);
        check("no_rd_wr_overlap", both, 0);
        check("accept_count", q_wr.size(), 18);
        check("writes_done", writes_done, 1);
        check("reads_done", reads_done, 1);
        for (int i = 0; i < 18 && i < q_wr.size(); i++) begin
            check($sformatf("acc%0d_is_write", i), q_wr[i], i < 9);
            check($sformatf("acc%0d_addr", i), q_addr[i], i % 9);
            if (i < 9)
                check($sformatf("acc%0d_wdata", i), q_wdata[i], PAT ^ 64'(i));
        end
        q_wr.delete(); q_addr.delete(); q_wdata.delete();
        repeat (20) step();
        check("finished_idle", q_wr.size(), 0);

        // Reset in the middle of the write phase
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (avl_write_req && avl_addr == 5) found = 1'b1;
            else step();
        end
        check("mid_reach_addr5", found, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr", avl_write_req, 0);
        check("mid_rst_bb", avl_burstbegin, 0);
        check("mid_rst_wd", writes_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (avl_write_req) found = 1'b1;
            else step();
        end
        check("restart_req", found, 1);
        check("restart_addr", avl_addr, 0);
        check("restart_wdata", avl_wdata, PAT);

`ifdef DDR3_TEST_GEN_OUTSTANDING_LIMIT_EN
        // Read-in-flight limit of 2 with read data withheld
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (avl_read_req) found = 1'b1;
            else step();
        end
        check("lim_reach_read", found, 1);
        n_rd = 0;
        repeat (10) step();
        check("lim_two_reads", n_rd, 2);
        check("lim_req_low", avl_read_req, 0);
        avl_rdata_valid = 1'b1;
        n_rd = 0;
        step();
        avl_rdata_valid = 1'b0;
        repeat (10) step();
        check("lim_one_more", n_rd, 1);
        avl_rdata_valid = 1'b1;
        step();
        avl_rdata_valid = 1'b0;
        check("lim_reassert", avl_read_req, 1);
        avl_rdata_valid = 1'b1;
        n_rd = 0;
        step();
        avl_rdata_valid = 1'b0;
        repeat (10) step();
        check("lim_acc_and_valid", n_rd, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
